// File: rtl/avg_sequencer.sv
// AVG instruction sequencer: fetches 4 display-list bytes per instruction, hands the word
// to avg_decode, steps the PC from the decoded fields, keeps a JSR return stack and
// hands vector instructions to the vector generator through a draw_req/draw_ack handshake.
module avg_sequencer #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned START_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              go,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_rdata,
    output logic [31:0]       inst,
    input  logic              jmp,
    input  logic              jsr,
    input  logic              ret,
    input  logic              halt,
    input  logic              vector,
    input  logic [15:0]       jumpAddr,
    input  logic [2:0]        pcOffset,
    input  logic [2:0]        instLength,
    output logic              exec_en,
    output logic              draw_req,
    input  logic              draw_ack,
    output logic              running,
    output logic              halted,
    output logic              stk_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_DRAW   = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

    // sp needs one extra bit so a full stack (sp == STACK_DEPTH) is representable
    localparam int unsigned SP_W     = $clog2(STACK_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [2:0]        k_q, k_d;      // fetch cycle index 0..4
    logic [2:0]        cnt_q, cnt_d;  // EXEC cycle index, 0 marks the exec_en cycle
    logic [2:0]        len_q, len_d;  // effective EXEC length latched on the first cycle
    logic [31:0]       inst_q, inst_d;
    logic              draw_req_q, draw_req_d;
    logic              stk_err_q, stk_err_d;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic              push_en;
    logic [SP_W-2:0]   push_idx;
    logic [SP_W-2:0]   pop_idx;

    logic [ADDR_W-1:0] pc_step;
    logic [ADDR_W-1:0] jump_pc;
    logic [15:0]       jump_ext;
    logic [2:0]        eff_len;
    logic              unused_jump;

    assign pc_step     = pc_q + ADDR_W'({pcOffset, 1'b0});
    assign jump_ext    = jumpAddr;
    assign jump_pc     = jump_ext[ADDR_W-1:0];
    assign unused_jump = ^jumpAddr;
    assign eff_len     = (instLength == 3'd0) ? 3'd1 : instLength;
    assign push_idx    = sp_q[SP_W-2:0];
    assign pop_idx     = sp_q[SP_W-2:0] - (SP_W-1)'(1);

    // Outputs decoded from registered state so reset clears them asynchronously
    always_comb begin
        ram_rd_en = (state_q == ST_FETCH) && (k_q != 3'd4);
        ram_addr  = ram_rd_en ? (pc_q + ADDR_W'(k_q)) : '0;
        exec_en   = (state_q == ST_EXEC) && (cnt_q == 3'd0);
        inst      = inst_q;
        draw_req  = draw_req_q;
        stk_err   = stk_err_q;
        running   = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_DRAW);
        halted    = (state_q == ST_HALTED);
    end

    // Next-state logic; go overrides everything else in every state
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        sp_d       = sp_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        inst_d     = inst_q;
        draw_req_d = draw_req_q;
        stk_err_d  = stk_err_q;
        push_en    = 1'b0;

        if (go) begin
            state_d    = ST_FETCH;
            pc_d       = START_PC;
            sp_d       = '0;
            stk_err_d  = 1'b0;
            k_d        = 3'd0;
            cnt_d      = 3'd0;
            draw_req_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_FETCH: begin
                    // Data read in cycle k-1 arrives in cycle k
                    case (k_q)
                        3'd1:    inst_d[31:24] = ram_rdata;
                        3'd2:    inst_d[23:16] = ram_rdata;
                        3'd3:    inst_d[15:8]  = ram_rdata;
                        3'd4:    inst_d[7:0]   = ram_rdata;
                        default: ;
                    endcase
                    if (k_q == 3'd4) begin
                        k_d     = 3'd0;
                        cnt_d   = 3'd0;
                        state_d = ST_EXEC;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 3'd0) begin
                        if (halt) begin
                            state_d = ST_HALTED;
                        end else if (vector) begin
                            state_d    = ST_DRAW;
                            draw_req_d = 1'b1;
                        end else begin
                            if (jsr) begin
                                if (sp_q == SP_FULL) begin
                                    stk_err_d = 1'b1;
                                    state_d   = ST_ERROR;
                                end else begin
                                    push_en = 1'b1;
                                    sp_d    = sp_q + SP_W'(1);
                                    pc_d    = jump_pc;
                                end
                            end else if (jmp) begin
                                pc_d = jump_pc;
                            end else if (ret) begin
                                if (sp_q == '0) begin
                                    stk_err_d = 1'b1;
                                    state_d   = ST_ERROR;
                                end else begin
                                    sp_d = sp_q - SP_W'(1);
                                    pc_d = stack_q[pop_idx];
                                end
                            end else begin
                                pc_d = pc_step;
                            end
                            if (state_d == ST_EXEC) begin
                                if (eff_len == 3'd1) begin
                                    state_d = ST_FETCH;
                                end else begin
                                    cnt_d = 3'd1;
                                    len_d = eff_len;
                                end
                            end
                        end
                    end else if (cnt_q == len_q - 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = ST_FETCH;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_DRAW: begin
                    if (draw_ack) begin
                        draw_req_d = 1'b0;
                        pc_d       = pc_step;
                        state_d    = ST_FETCH;
                    end
                end
                ST_HALTED: begin
                end
                ST_ERROR: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= ST_IDLE;
            pc_q       <= START_PC;
            sp_q       <= '0;
            k_q        <= 3'd0;
            cnt_q      <= 3'd0;
            len_q      <= 3'd1;
            inst_q     <= 32'd0;
            draw_req_q <= 1'b0;
            stk_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            inst_q     <= inst_d;
            draw_req_q <= draw_req_d;
            stk_err_q  <= stk_err_d;
        end
    end

    // Return-stack storage; validity is tracked by sp alone, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_step;
        end
    end

endmodule

// File: tb/tb_avg_sequencer.sv
// Directed bench for avg_sequencer with a byte RAM model, a toy decoder and a scoreboard
// of expected fetch addresses and instruction words.
module tb_avg_sequencer;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        go = 1'b0;
    logic        ram_rd_en;
    logic [12:0] ram_addr;
    logic [7:0]  ram_rdata;
    logic [31:0] inst;
    logic        jmp, jsr, ret, halt, vector;
    logic [15:0] jumpAddr;
    logic [2:0]  pcOffset, instLength;
    logic        exec_en, draw_req, running, halted, stk_err;
    logic        draw_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [8192];
    logic [12:0] exp_addr [$];
    logic [31:0] exp_inst [$];

    avg_sequencer #(.ADDR_W(13), .STACK_DEPTH(4), .START_ADDR(0)) dut (
        .clk(clk), .rst_l(rst_l), .go(go),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .inst(inst), .jmp(jmp), .jsr(jsr), .ret(ret), .halt(halt), .vector(vector),
        .jumpAddr(jumpAddr), .pcOffset(pcOffset), .instLength(instLength),
        .exec_en(exec_en), .draw_req(draw_req), .draw_ack(draw_ack),
        .running(running), .halted(halted), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    // RAM with 1-cycle read latency
    always @(posedge clk) if (ram_rd_en) ram_rdata <= mem[ram_addr];

    // Toy decoder: opcode in inst[31:28]; 0 VCTR, 1 SVEC, 2 HALT, 3 JSR, 4 JMP, 5 RTS,
    // 6 STAT (length in inst[18:16]), others unknown
    always_comb begin
        jmp = 0; jsr = 0; ret = 0; halt = 0; vector = 0;
        jumpAddr = inst[15:0]; pcOffset = 3'd1; instLength = 3'd1;
        case (inst[31:28])
            4'h0: begin vector = 1; pcOffset = 3'd2; end
            4'h1: vector = 1;
            4'h2: halt = 1;
            4'h3: begin jsr = 1; pcOffset = 3'd2; end
            4'h4: begin jmp = 1; pcOffset = 3'd2; end
            4'h5: ret = 1;
            4'h6: instLength = inst[18:16];
            default: begin pcOffset = 3'd0; instLength = 3'd0; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop an expectation whenever the DUT fetches or issues exec_en
    always @(negedge clk) begin
        if (ram_rd_en) begin
            chk("fetch_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) chk("ram_addr", 32'(ram_addr), 32'(exp_addr.pop_front()));
        end
        if (exec_en) begin
            chk("exec_expected", 32'(exp_inst.size() != 0), 32'd1);
            if (exp_inst.size() != 0) chk("inst", inst, exp_inst.pop_front());
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    endtask

    task automatic put_word(input logic [12:0] addr, input logic [31:0] w);
        logic [12:0] a;
        a = addr;
        for (int i = 0; i < 4; i++) begin
            mem[a] = w[31-8*i -: 8];
            a = a + 13'd1;
        end
    endtask

    // Expect a full 4-byte fetch at addr and the resulting word at exec_en
    task automatic expect_inst(input logic [12:0] addr, input logic [31:0] w);
        logic [12:0] a;
        a = addr;
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(a);
            a = a + 13'd1;
        end
        exp_inst.push_back(w);
    endtask

    task automatic pulse_go();
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
    endtask

    // sel: 0 halted, 1 draw_req, 2 stk_err, 3 exec_en
    task automatic wait_for(input string tag, input int sel, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (i != 0 || sel != 1) @(negedge clk);
            case (sel)
                0: seen = halted;
                1: seen = draw_req;
                2: seen = stk_err;
                default: seen = exec_en;
            endcase
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic sb_empty(input string tag);
        chk(tag, 32'(exp_addr.size() + exp_inst.size()), 32'd0);
    endtask

    initial begin
        int bad;
        int n;
        int ex;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_running", 32'(running), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_stk_err", 32'(stk_err), 0);
        chk("rst_draw_req", 32'(draw_req), 0);
        chk("rst_exec_en", 32'(exec_en), 0);
        chk("rst_ram_rd_en", 32'(ram_rd_en), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_inst", inst, 0);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_run", 32'(running), 0);

        // 1: SVEC then HALT
        clear_mem();
        put_word(13'h000, 32'h10AA2000);
        expect_inst(13'h000, 32'h10AA2000);
        expect_inst(13'h002, 32'h20000000);
        pulse_go();
        chk("t1_running", 32'(running), 1);
        wait_for("t1_draw_wait", 1, 30);
        bad = 0;
        repeat (3) begin @(negedge clk); if (draw_req !== 1'b1) bad++; end
        chk("t1_draw_held", 32'(bad), 0);
        draw_ack = 1'b1;
        @(negedge clk) draw_ack = 1'b0;
        chk("t1_draw_drop", 32'(draw_req), 0);
        wait_for("t1_halt_wait", 0, 30);
        chk("t1_halted", 32'(halted), 1);
        chk("t1_not_running", 32'(running), 0);
        sb_empty("t1_sb_empty");

        // 2: JMP 0x10, JSR 0x100, RTS back to 0x14, HALT
        clear_mem();
        put_word(13'h000, 32'h40000010);
        put_word(13'h010, 32'h30000100);
        put_word(13'h100, 32'h50000000);
        put_word(13'h014, 32'h20000000);
        expect_inst(13'h000, 32'h40000010);
        expect_inst(13'h010, 32'h30000100);
        expect_inst(13'h100, 32'h50000000);
        expect_inst(13'h014, 32'h20000000);
        pulse_go();
        wait_for("t2_halt_wait", 0, 80);
        chk("t2_stk_err", 32'(stk_err), 0);
        sb_empty("t2_sb_empty");

        // 3: five nested JSRs overflow a 4-deep stack; then RTS with empty stack
        clear_mem();
        for (int i = 0; i < 5; i++) begin
            put_word(13'(32 * i), 32'h30000000 | 32'(32 * (i + 1)));
            expect_inst(13'(32 * i), 32'h30000000 | 32'(32 * (i + 1)));
        end
        pulse_go();
        wait_for("t3_ovf_wait", 2, 80);
        chk("t3_ovf_running", 32'(running), 0);
        chk("t3_ovf_halted", 32'(halted), 0);
        repeat (5) @(negedge clk);
        chk("t3_ovf_sticky", 32'(stk_err), 1);
        sb_empty("t3_ovf_sb_empty");
        clear_mem();
        put_word(13'h000, 32'h50000000);
        expect_inst(13'h000, 32'h50000000);
        pulse_go();
        chk("t3_go_clears", 32'(stk_err), 0);
        wait_for("t3_unf_wait", 2, 30);
        chk("t3_unf_running", 32'(running), 0);
        sb_empty("t3_unf_sb_empty");

        // 4: long draw stall
        clear_mem();
        put_word(13'h000, 32'h00112233);
        put_word(13'h004, 32'h20000000);
        expect_inst(13'h000, 32'h00112233);
        expect_inst(13'h004, 32'h20000000);
        pulse_go();
        wait_for("t4_draw_wait", 1, 30);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (draw_req !== 1'b1 || ram_rd_en !== 1'b0) bad++;
        end
        chk("t4_stall", 32'(bad), 0);
        draw_ack = 1'b1;
        @(negedge clk) draw_ack = 1'b0;
        wait_for("t4_halt_wait", 0, 30);
        sb_empty("t4_sb_empty");

        // 5: STAT with instLength 6
        clear_mem();
        put_word(13'h000, 32'h60062000);
        expect_inst(13'h000, 32'h60062000);
        expect_inst(13'h002, 32'h20000000);
        pulse_go();
        wait_for("t5_exec_wait", 3, 30);
        n = 1;
        ex = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ram_rd_en) break;
            n++;
            if (exec_en) ex++;
        end
        chk("t5_exec_cycles", 32'(n), 32'd6);
        chk("t5_exec_en_once", 32'(ex), 32'd1);
        wait_for("t5_halt_wait", 0, 30);
        sb_empty("t5_sb_empty");

        // 6: fetch wrapping at top of RAM, then async reset mid-draw
        clear_mem();
        put_word(13'h000, 32'h40001FFE);
        mem[13'h1FFE] = 8'h0A;
        mem[13'h1FFF] = 8'hBC;
        expect_inst(13'h000, 32'h40001FFE);
        expect_inst(13'h1FFE, 32'h0ABC4000);
        pulse_go();
        wait_for("t6_draw_wait", 1, 40);
        @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        chk("t6_rst_draw_req", 32'(draw_req), 0);
        chk("t6_rst_running", 32'(running), 0);
        chk("t6_rst_inst", inst, 0);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_post_rst_idle", 32'(running | draw_req | halted), 0);
        sb_empty("t6_sb_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
